text_console_writer: RTL and testbench



---
 rtl/text_console_pkg.sv | 18 +
 rtl/text_console_writer_blink_gen.sv | 24 ++
 rtl/text_console_writer.sv | 160 ++++++++++++++++
 tb/tb_text_console_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and address helper for the text console writer.
package text_console_pkg;
  localparam logic [7:0]  CC_BS = 8'h08;
  localparam logic [7:0]  CC_LF = 8'h0A;
  localparam logic [7:0]  CC_FF = 8'h0C;
  localparam logic [7:0]  CC_CR = 8'h0D;
  localparam logic [10:0] BLANK_CELL_DEFAULT = 11'h720;
  localparam int          CELLS = 1200;

  typedef enum logic [1:0] {ST_IDLE, ST_PUT, ST_CLR_ROW, ST_CLR_ALL} state_t;

  // row*40 built from shifts so no multiplier is inferred
  function automatic logic [12:0] row_base(input logic [4:0] row);
    logic [12:0] r;
    r = {8'd0, row};
    return (r << 5) + (r << 3);
  endfunction
endpackage

// File: rtl/text_console_writer_blink_gen.sv
// Free-running cursor blink square wave, toggling every BLINK_HALF cycles.
module blink_gen #(
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic vga_clk,
  input  logic rst,
  output logic Blink
);
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      cnt   <= '0;
      Blink <= 1'b0;
    end else if (cnt == CW'(BLINK_HALF - 1)) begin
      cnt   <= '0;
      Blink <= ~Blink;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/text_console_writer.sv
// Character stream to text VRAM writer: cursor, control codes, row/screen clears.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter logic [10:0] BLANK_CELL = BLANK_CELL_DEFAULT,
  parameter int          BLINK_HALF = 12_500_000
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic [2:0]  color_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic        vram_we,
  output logic [12:0] vram_wr_addr,
  output logic [10:0] vram_wr_data,
  output logic [12:0] Cursor,
  output logic        Blink,
  output logic        busy
);
  state_t      state, state_nxt, put_after, put_after_nxt;
  logic [10:0] cnt, cnt_nxt;
  logic [4:0]  row, row_nxt, row_inc;
  logic [5:0]  col, col_nxt;
  logic        we_nxt, ready_nxt, busy_nxt;
  logic [12:0] addr_nxt;
  logic [10:0] data_nxt;

  assign row_inc = (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
  assign Cursor  = {1'b0, row, 1'b0, col};

  // Outputs are loaded together with the state they belong to, so every
  // visible write/ready/busy value lines up with the state it is shown in.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state        <= ST_CLR_ALL;
      put_after    <= ST_IDLE;
      cnt          <= '0;
      row          <= '0;
      col          <= '0;
      vram_we      <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      char_ready   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      put_after    <= put_after_nxt;
      cnt          <= cnt_nxt;
      row          <= row_nxt;
      col          <= col_nxt;
      vram_we      <= we_nxt;
      vram_wr_addr <= addr_nxt;
      vram_wr_data <= data_nxt;
      char_ready   <= ready_nxt;
      busy         <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    put_after_nxt = put_after;
    cnt_nxt       = cnt;
    row_nxt       = row;
    col_nxt       = col;
    we_nxt        = 1'b0;
    addr_nxt      = vram_wr_addr;
    data_nxt      = vram_wr_data;
    ready_nxt     = 1'b0;
    busy_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        if (char_valid && char_ready) begin
          ready_nxt     = 1'b0;
          state_nxt     = ST_PUT;
          put_after_nxt = ST_IDLE;
          case (char_in)
            CC_LF: begin
              col_nxt       = '0;
              row_nxt       = row_inc;
              put_after_nxt = ST_CLR_ROW;
            end
            CC_CR: col_nxt = '0;
            CC_BS: begin
              if (col != 6'd0) begin
                col_nxt  = col - 6'd1;
                we_nxt   = 1'b1;
                addr_nxt = row_base(row) + {7'd0, col - 6'd1};
                data_nxt = {color_in, 8'h20};
              end
            end
            CC_FF: begin
              row_nxt       = '0;
              col_nxt       = '0;
              put_after_nxt = ST_CLR_ALL;
            end
            default: begin
              we_nxt   = 1'b1;
              addr_nxt = row_base(row) + {7'd0, col};
              data_nxt = {color_in, char_in};
              if (col == 6'(COLS - 1)) begin
                col_nxt       = '0;
                row_nxt       = row_inc;
                put_after_nxt = ST_CLR_ROW;
              end else begin
                col_nxt = col + 6'd1;
              end
            end
          endcase
        end
      end
      ST_PUT: begin
        state_nxt = put_after;
        if (put_after == ST_IDLE) begin
          ready_nxt = 1'b1;
        end else begin
          // first blank cell is issued on clear entry; cnt counts cells issued
          we_nxt   = 1'b1;
          addr_nxt = (put_after == ST_CLR_ROW) ? row_base(row) : 13'd0;
          data_nxt = BLANK_CELL;
          cnt_nxt  = 11'd1;
          busy_nxt = 1'b1;
        end
      end
      ST_CLR_ROW: begin
        if (cnt == 11'(COLS)) begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
        end else begin
          we_nxt   = 1'b1;
          addr_nxt = row_base(row) + {2'd0, cnt};
          data_nxt = BLANK_CELL;
          cnt_nxt  = cnt + 11'd1;
          busy_nxt = 1'b1;
        end
      end
      default: begin
        if (cnt == 11'(CELLS)) begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
        end else begin
          we_nxt   = 1'b1;
          addr_nxt = {2'd0, cnt};
          data_nxt = BLANK_CELL;
          cnt_nxt  = cnt + 11'd1;
          busy_nxt = 1'b1;
        end
      end
    endcase
  end

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .vga_clk(vga_clk),
    .rst    (rst),
    .Blink  (Blink)
  );
endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer (BLINK_HALF shortened to 4).
module tb_text_console_writer;
  logic        vga_clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic [2:0]  color_in = 3'd0;
  logic        char_valid = 1'b0;
  logic        char_ready, vram_we, Blink, busy;
  logic [12:0] vram_wr_addr, Cursor;
  logic [10:0] vram_wr_data;

  int ncmp = 0;
  int nfail = 0;

  text_console_writer #(.BLINK_HALF(4)) dut (
    .vga_clk     (vga_clk),
    .rst         (rst),
    .char_in     (char_in),
    .color_in    (color_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .vram_we     (vram_we),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .Cursor      (Cursor),
    .Blink       (Blink),
    .busy        (busy)
  );

  always #5 vga_clk = ~vga_clk;

  // Present one byte and hold it until accepted; returns at #1 into the PUT cycle.
  task automatic send(input logic [7:0] c, input logic [2:0] clr);
    bit ok;
    ok = 0;
    char_in = c; color_in = clr; char_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (char_ready) ok = 1;
      @(posedge vga_clk); #1;
    end
    char_valid = 1'b0;
    ncmp++;
    if (!ok) begin nfail++; $display("FAIL send_timeout: char %h not accepted", c); end
  endtask

  // Runs a full-screen clear after reset and checks its write sequence.
  task automatic check_full_clear(input string tag);
    int nw, bad_addr, bad_data, bad_rdy;
    bit done;
    nw = 0; bad_addr = 0; bad_data = 0; bad_rdy = 0; done = 0;
    for (int i = 0; i < 1400 && !done; i++) begin
      @(posedge vga_clk); #1;
      if (vram_we) begin
        if (vram_wr_addr !== 13'(nw)) bad_addr++;
        if (vram_wr_data !== 11'h720) bad_data++;
        if (char_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
        nw++;
      end
      if (char_ready === 1'b1) done = 1;
    end
    ncmp++; if (nw != 1200) begin nfail++; $display("FAIL %s_count: got %0d writes, expected 1200", tag, nw); end
    ncmp++; if (bad_addr != 0) begin nfail++; $display("FAIL %s_addr: %0d out-of-order addresses, expected 0", tag, bad_addr); end
    ncmp++; if (bad_data != 0) begin nfail++; $display("FAIL %s_data: %0d non-blank cells, expected 0", tag, bad_data); end
    ncmp++; if (bad_rdy != 0) begin nfail++; $display("FAIL %s_ready_busy: %0d bad cycles, expected 0", tag, bad_rdy); end
    ncmp++; if (Cursor !== 13'h0000) begin nfail++; $display("FAIL %s_cursor: got %h expected 0000", tag, Cursor); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge vga_clk); #1;
    ncmp++; if (vram_we !== 1'b0 || busy !== 1'b0 || char_ready !== 1'b0) begin
      nfail++; $display("FAIL reset_ctrl: we=%b busy=%b ready=%b expected 0 0 0", vram_we, busy, char_ready); end
    ncmp++; if (vram_wr_addr !== 13'd0 || vram_wr_data !== 11'd0) begin
      nfail++; $display("FAIL reset_bus: addr=%h data=%h expected 0 0", vram_wr_addr, vram_wr_data); end
    ncmp++; if (Cursor !== 13'd0 || Blink !== 1'b0) begin
      nfail++; $display("FAIL reset_cursor_blink: cursor=%h blink=%b expected 0 0", Cursor, Blink); end
    rst = 1'b0;
    check_full_clear("reset_clear");
  endtask

  task automatic test_put_char();
    send(8'h41, 3'b010);
    ncmp++; if (vram_we !== 1'b1 || vram_wr_addr !== 13'd0 || vram_wr_data !== 11'h241) begin
      nfail++; $display("FAIL put_write: we=%b addr=%h data=%h expected 1 0000 241", vram_we, vram_wr_addr, vram_wr_data); end
    ncmp++; if (Cursor !== 13'h0001 || char_ready !== 1'b0) begin
      nfail++; $display("FAIL put_cursor: cursor=%h ready=%b expected 0001 0", Cursor, char_ready); end
    @(posedge vga_clk); #1;
    ncmp++; if (char_ready !== 1'b1 || vram_we !== 1'b0) begin
      nfail++; $display("FAIL put_ready: ready=%b we=%b expected 1 0", char_ready, vram_we); end
  endtask

  task automatic test_row_wrap();
    int bad, nw, bad_addr, bad_rdy;
    logic [10:0] exp;
    bit done;
    send(8'h0D, 3'd0);
    ncmp++; if (vram_we !== 1'b0 || Cursor !== 13'h0000) begin
      nfail++; $display("FAIL cr_put: we=%b cursor=%h expected 0 0000", vram_we, Cursor); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      exp = {3'(i % 8), 8'(8'h61 + i % 26)};
      send(exp[7:0], exp[10:8]);
      if (vram_we !== 1'b1 || vram_wr_addr !== 13'(i) || vram_wr_data !== exp) bad++;
    end
    ncmp++; if (bad != 0) begin nfail++; $display("FAIL row0_writes: %0d bad writes, expected 0", bad); end
    ncmp++; if (Cursor !== 13'h0080) begin nfail++; $display("FAIL wrap_cursor: got %h expected 0080", Cursor); end
    nw = 0; bad_addr = 0; bad_rdy = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge vga_clk); #1;
      if (vram_we) begin
        if (vram_wr_addr !== 13'(40 + nw) || vram_wr_data !== 11'h720) bad_addr++;
        if (char_ready !== 1'b0) bad_rdy++;
        nw++;
      end
      if (char_ready === 1'b1) done = 1;
    end
    ncmp++; if (nw != 40) begin nfail++; $display("FAIL rowclr_count: got %0d expected 40", nw); end
    ncmp++; if (bad_addr != 0 || bad_rdy != 0) begin
      nfail++; $display("FAIL rowclr_seq: bad_addr=%0d bad_ready=%0d expected 0 0", bad_addr, bad_rdy); end
  endtask

  task automatic test_back_to_back();
    int nacc, nblank, nq, bad_blank;
    logic [12:0] qaddr;
    bit acc;
    nacc = 0; nblank = 0; nq = 0; bad_blank = 0; qaddr = '0;
    char_in = 8'h0A; color_in = 3'd0; char_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      acc = char_valid && char_ready;
      @(posedge vga_clk); #1;
      if (acc) begin
        nacc++;
        if (nacc == 1) begin char_in = 8'h51; color_in = 3'd5; end
        else char_valid = 1'b0;
      end
      if (vram_we && vram_wr_data === 11'h720) begin
        if (vram_wr_addr < 13'd80 || vram_wr_addr > 13'd119) bad_blank++;
        nblank++;
      end
      if (vram_we && vram_wr_data === 11'h551) begin nq++; qaddr = vram_wr_addr; end
    end
    char_valid = 1'b0;
    ncmp++; if (nacc != 2) begin nfail++; $display("FAIL hold_accepts: got %0d expected 2", nacc); end
    ncmp++; if (nblank != 40 || bad_blank != 0) begin
      nfail++; $display("FAIL hold_clear: blanks=%0d stray=%0d expected 40 0", nblank, bad_blank); end
    ncmp++; if (nq != 1 || qaddr !== 13'd80) begin
      nfail++; $display("FAIL hold_char: writes=%0d addr=%0d expected 1 80", nq, qaddr); end
    ncmp++; if (Cursor !== 13'h0101) begin nfail++; $display("FAIL hold_cursor: got %h expected 0101", Cursor); end
  endtask

  task automatic test_newline_wrap();
    int nw, bad, stray;
    bit done;
    send(8'h0D, 3'd0);
    for (int i = 0; i < 27; i++) send(8'h0A, 3'd0);
    for (int i = 0; i < 7; i++) send(8'h30 + 8'(i), 3'd1);
    ncmp++; if (Cursor !== {1'b0, 5'd29, 1'b0, 6'd7}) begin
      nfail++; $display("FAIL nl_setup: cursor=%h expected %h", Cursor, {1'b0, 5'd29, 1'b0, 6'd7}); end
    send(8'h0A, 3'd3);
    ncmp++; if (vram_we !== 1'b0 || Cursor !== 13'h0000) begin
      nfail++; $display("FAIL nl_put: we=%b cursor=%h expected 0 0000", vram_we, Cursor); end
    nw = 0; bad = 0; stray = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge vga_clk); #1;
      if (vram_we) begin
        if (vram_wr_addr === 13'd1167) stray++;
        if (vram_wr_addr !== 13'(nw) || vram_wr_data !== 11'h720) bad++;
        nw++;
      end
      if (char_ready === 1'b1) done = 1;
    end
    ncmp++; if (nw != 40 || bad != 0) begin
      nfail++; $display("FAIL nl_clear: writes=%0d bad=%0d expected 40 0", nw, bad); end
    ncmp++; if (stray != 0) begin nfail++; $display("FAIL nl_stray: %0d writes at 1167, expected 0", stray); end
  endtask

  task automatic test_backspace();
    send(8'h0A, 3'd0);
    send(8'h0A, 3'd0);
    for (int i = 0; i < 5; i++) send(8'h61, 3'd2);
    send(8'h08, 3'b100);
    ncmp++; if (vram_we !== 1'b1 || vram_wr_addr !== 13'd84 || vram_wr_data !== 11'h420) begin
      nfail++; $display("FAIL bs_write: we=%b addr=%0d data=%h expected 1 84 420", vram_we, vram_wr_addr, vram_wr_data); end
    ncmp++; if (Cursor !== 13'h0104) begin nfail++; $display("FAIL bs_cursor: got %h expected 0104", Cursor); end
    send(8'h0D, 3'd0);
    send(8'h08, 3'b100);
    ncmp++; if (vram_we !== 1'b0 || Cursor !== 13'h0100) begin
      nfail++; $display("FAIL bs_col0: we=%b cursor=%h expected 0 0100", vram_we, Cursor); end
    @(posedge vga_clk); #1;
    ncmp++; if (vram_we !== 1'b0 || char_ready !== 1'b1) begin
      nfail++; $display("FAIL bs_col0_after: we=%b ready=%b expected 0 1", vram_we, char_ready); end
  endtask

  task automatic test_blink();
    logic prev, first, exp;
    bit found;
    int bad;
    prev = Blink; found = 0; bad = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge vga_clk); #1;
      if (Blink !== prev) found = 1;
    end
    ncmp++; if (!found) begin nfail++; $display("FAIL blink_toggle: no toggle within 8 cycles, expected one"); end
    first = Blink;
    for (int k = 1; k <= 16; k++) begin
      @(posedge vga_clk); #1;
      exp = first ^ 1'((k / 4) % 2);
      if (Blink !== exp) bad++;
    end
    ncmp++; if (bad != 0) begin nfail++; $display("FAIL blink_period: %0d wrong samples, expected 0", bad); end
  endtask

  task automatic test_ff_reset();
    send(8'h0D, 3'd0);
    for (int i = 0; i < 3; i++) send(8'h62, 3'd6);
    send(8'h0C, 3'd0);
    ncmp++; if (vram_we !== 1'b0 || Cursor !== 13'h0000) begin
      nfail++; $display("FAIL ff_put: we=%b cursor=%h expected 0 0000", vram_we, Cursor); end
    @(posedge vga_clk); #1;
    ncmp++; if (busy !== 1'b1 || vram_we !== 1'b1 || vram_wr_addr !== 13'd0 || vram_wr_data !== 11'h720) begin
      nfail++; $display("FAIL ff_clear_start: busy=%b we=%b addr=%0d data=%h expected 1 1 0 720",
                        busy, vram_we, vram_wr_addr, vram_wr_data); end
    repeat (50) @(posedge vga_clk);
    #1;
    rst = 1'b1;
    @(posedge vga_clk); #1;
    ncmp++; if (vram_we !== 1'b0 || busy !== 1'b0 || char_ready !== 1'b0 || Blink !== 1'b0) begin
      nfail++; $display("FAIL ff_reset_wins: we=%b busy=%b ready=%b blink=%b expected 0 0 0 0",
                        vram_we, busy, char_ready, Blink); end
    rst = 1'b0;
    check_full_clear("ff_reclear");
  endtask

  initial begin
    test_reset();
    test_put_char();
    test_row_wrap();
    test_back_to_back();
    test_newline_wrap();
    test_backspace();
    test_blink();
    test_ff_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
